// File: rtl/ps2_key_decoder_if.sv
// PS/2 line inputs and decoded key outputs shared between the keyboard front end and the game control FSM.
interface ps2_key_decoder_if;
    logic       i_ps2_clk;
    logic       i_ps2_dat;
    logic [7:0] o_key;
    logic       o_key_ext;
    logic       o_key_press;
    logic       o_key_release;
    logic       o_frame_err;

    modport master (
        output i_ps2_clk, i_ps2_dat,
        input  o_key, o_key_ext, o_key_press, o_key_release, o_frame_err
    );

    modport slave (
        input  i_ps2_clk, i_ps2_dat,
        output o_key, o_key_ext, o_key_press, o_key_release, o_frame_err
    );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: conditions the raw lines, frames 11-bit words, checks them,
// and turns make/break/E0 sequences into a held-key code with press/release pulses.
module ps2_key_decoder #(
    parameter int FILTER_LEN = 8,
    parameter int TIMEOUT    = 100000,
    parameter int CNT_W      = 17
) (
    input  logic               i_clock,
    input  logic               i_reset,
    ps2_key_decoder_if.slave   bus
);
    localparam int FW = $clog2(FILTER_LEN + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DATA   = 2'd1;
    localparam logic [1:0] S_PARITY = 2'd2;
    localparam logic [1:0] S_STOP   = 2'd3;

    localparam logic [CNT_W-1:0] TO_MAX = CNT_W'(TIMEOUT);

    logic          r_clk_s1, r_clk_s2, r_dat_s1, r_dat_s2;
    logic          r_filt_clk, r_filt_prev;
    logic [FW-1:0] r_filt_cnt;
    logic          w_fall;

    logic [1:0]       r_state;
    logic [2:0]       r_bitcnt;
    logic [7:0]       r_shift;
    logic             r_parity;
    logic [CNT_W-1:0] r_to_cnt;
    logic             r_byte_rdy;
    logic             r_frame_err;

    logic [7:0] r_key;
    logic       r_key_ext, r_held, r_ext_pend, r_brk_pend;
    logic       r_key_press, r_key_release;
    logic       w_match;

    // Filtered clock follows the synced line only after FILTER_LEN consecutive differing samples.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_clk_s1    <= 1'b1;
            r_clk_s2    <= 1'b1;
            r_dat_s1    <= 1'b1;
            r_dat_s2    <= 1'b1;
            r_filt_clk  <= 1'b1;
            r_filt_prev <= 1'b1;
            r_filt_cnt  <= '0;
        end else begin
            r_clk_s1    <= bus.i_ps2_clk;
            r_clk_s2    <= r_clk_s1;
            r_dat_s1    <= bus.i_ps2_dat;
            r_dat_s2    <= r_dat_s1;
            r_filt_prev <= r_filt_clk;
            if (r_clk_s2 == r_filt_clk) begin
                r_filt_cnt <= '0;
            end else if (r_filt_cnt == FW'(FILTER_LEN - 1)) begin
                r_filt_clk <= r_clk_s2;
                r_filt_cnt <= '0;
            end else begin
                r_filt_cnt <= r_filt_cnt + 1'b1;
            end
        end
    end

    assign w_fall = r_filt_prev & ~r_filt_clk;

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_bitcnt    <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_to_cnt    <= '0;
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_byte_rdy  <= 1'b0;
            r_frame_err <= 1'b0;

            if (r_state == S_IDLE || w_fall)
                r_to_cnt <= '0;
            else if (r_to_cnt != TO_MAX)
                r_to_cnt <= r_to_cnt + 1'b1;

            if (r_state != S_IDLE && r_to_cnt == TO_MAX) begin
                r_state     <= S_IDLE;
                r_frame_err <= 1'b1;
            end else if (w_fall) begin
                case (r_state)
                    S_IDLE: begin
                        if (!r_dat_s2) begin
                            r_state  <= S_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    S_DATA: begin
                        r_shift  <= {r_dat_s2, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7)
                            r_state <= S_PARITY;
                    end
                    S_PARITY: begin
                        r_parity <= r_dat_s2;
                        r_state  <= S_STOP;
                    end
                    default: begin
                        if (r_dat_s2 && (^r_shift ^ r_parity))
                            r_byte_rdy <= 1'b1;
                        else
                            r_frame_err <= 1'b1;
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // r_held distinguishes "no key" from a held code 00.
    assign w_match = r_held && (r_key == r_shift) && (r_key_ext == r_ext_pend);

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_key         <= '0;
            r_key_ext     <= 1'b0;
            r_held        <= 1'b0;
            r_ext_pend    <= 1'b0;
            r_brk_pend    <= 1'b0;
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
        end else begin
            r_key_press   <= 1'b0;
            r_key_release <= 1'b0;
            if (r_frame_err) begin
                r_ext_pend <= 1'b0;
                r_brk_pend <= 1'b0;
            end else if (r_byte_rdy) begin
                if (r_shift == 8'hE0) begin
                    r_ext_pend <= 1'b1;
                end else if (r_shift == 8'hF0) begin
                    r_brk_pend <= 1'b1;
                end else begin
                    r_ext_pend <= 1'b0;
                    r_brk_pend <= 1'b0;
                    if (r_brk_pend) begin
                        if (w_match) begin
                            r_key         <= '0;
                            r_key_ext     <= 1'b0;
                            r_held        <= 1'b0;
                            r_key_release <= 1'b1;
                        end
                    end else if (!w_match) begin
                        r_key       <= r_shift;
                        r_key_ext   <= r_ext_pend;
                        r_held      <= 1'b1;
                        r_key_press <= 1'b1;
                    end
                end
            end
        end
    end

    assign bus.o_key         = r_key;
    assign bus.o_key_ext     = r_key_ext;
    assign bus.o_key_press   = r_key_press;
    assign bus.o_key_release = r_key_release;
    assign bus.o_frame_err   = r_frame_err;
endmodule
